// File: rtl/softmax_argmax_stream.sv
// rtl/softmax_argmax_stream.sv - streaming signed argmax over LANES scores per beat, optional top-2 margin (SOFTMAX_TOP2_EN)
module softmax_argmax_stream #(
    parameter int DATA_W      = 8,
    parameter int IDX_W       = 5,
    parameter int LANES       = 4,
    parameter int NUM_CLASSES = 29
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_lane_en,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_err,
    output logic [DATA_W:0]         out_margin
);
    localparam int CW = IDX_W + 5;
    localparam int BW = IDX_W + 1;
    localparam int NW = IDX_W + 5;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W:0]    CNT_MAX  = '1;
    localparam logic [BW-1:0]     BEAT_MAX = '1;

    typedef enum logic {IDLE, ACCUM} state_t;
    state_t state, state_nxt;
    logic   seed;
    logic   accept;

    logic signed [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]         best_idx;
    logic                     best_has;
    logic [BW-1:0]            beat_cnt;
    logic [IDX_W:0]           cls_cnt;
    logic                     ovf;

    logic [CW-1:0]            lane_idx;
    logic signed [DATA_W-1:0] lane_sc;
    logic signed [DATA_W-1:0] b_val;
    logic [IDX_W-1:0]         b_idx;
    logic                     b_has;
    logic                     ovf_nxt;
    logic [3:0]               pc;
    logic [NW-1:0]            cnt_sum;
`ifdef SOFTMAX_TOP2_EN
    logic signed [DATA_W-1:0] sec_val;
    logic                     sec_has;
    logic signed [DATA_W-1:0] s_val;
    logic                     s_has;
    logic [DATA_W:0]          margin_nxt;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = in_last ? IDLE : ACCUM;
    end

    always_comb begin
        seed = (state == IDLE);
    end

    // Lanes are scanned in ascending order with strict '>' so ties keep the lower index.
    always_comb begin
        b_val    = seed ? MOST_NEG : best_val;
        b_idx    = seed ? '0 : best_idx;
        b_has    = seed ? 1'b0 : best_has;
        ovf_nxt  = seed ? 1'b0 : ovf;
`ifdef SOFTMAX_TOP2_EN
        s_val    = seed ? MOST_NEG : sec_val;
        s_has    = seed ? 1'b0 : sec_has;
`endif
        pc       = '0;
        lane_idx = '0;
        lane_sc  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx = CW'(beat_cnt) * CW'(LANES) + CW'(k);
            lane_sc  = in_data[k*DATA_W +: DATA_W];
            if (in_lane_en[k]) begin
                pc = pc + 4'd1;
                if (lane_idx >= CW'(2**IDX_W)) begin
                    ovf_nxt = 1'b1;
                end else if (!b_has || lane_sc > b_val) begin
`ifdef SOFTMAX_TOP2_EN
                    if (b_has) begin
                        s_val = b_val;
                        s_has = 1'b1;
                    end
`endif
                    b_val = lane_sc;
                    b_idx = lane_idx[IDX_W-1:0];
                    b_has = 1'b1;
                end
`ifdef SOFTMAX_TOP2_EN
                else if (!s_has || lane_sc > s_val) begin
                    s_val = lane_sc;
                    s_has = 1'b1;
                end
`endif
            end
        end
        cnt_sum = (seed ? '0 : NW'(cls_cnt)) + NW'(pc);
`ifdef SOFTMAX_TOP2_EN
        margin_nxt = !b_has ? '0 :
                     !s_has ? '1 :
                     ({b_val[DATA_W-1], b_val} - {s_val[DATA_W-1], s_val});
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            best_val  <= MOST_NEG;
            best_idx  <= '0;
            best_has  <= 1'b0;
            beat_cnt  <= '0;
            cls_cnt   <= '0;
            ovf       <= 1'b0;
`ifdef SOFTMAX_TOP2_EN
            sec_val    <= MOST_NEG;
            sec_has    <= 1'b0;
            out_margin <= '0;
`endif
        end else if (accept) begin
            if (in_last) begin
                out_valid <= 1'b1;
                out_index <= b_idx;
                out_data  <= b_val;
                out_err   <= ovf_nxt || (cnt_sum != NW'(NUM_CLASSES));
                best_val  <= MOST_NEG;
                best_idx  <= '0;
                best_has  <= 1'b0;
                beat_cnt  <= '0;
                cls_cnt   <= '0;
                ovf       <= 1'b0;
`ifdef SOFTMAX_TOP2_EN
                sec_val    <= MOST_NEG;
                sec_has    <= 1'b0;
                out_margin <= margin_nxt;
`endif
            end else begin
                best_val <= b_val;
                best_idx <= b_idx;
                best_has <= b_has;
                beat_cnt <= (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 1'b1;
                cls_cnt  <= (cnt_sum > NW'(CNT_MAX)) ? CNT_MAX : cnt_sum[IDX_W:0];
                ovf      <= ovf_nxt;
`ifdef SOFTMAX_TOP2_EN
                sec_val  <= s_val;
                sec_has  <= s_has;
`endif
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SOFTMAX_TOP2_EN
    assign out_margin = '0;
`endif
endmodule

// File: tb/tb_softmax_argmax_stream.sv
// tb/tb_softmax_argmax_stream.sv - table-driven and randomized bench for softmax_argmax_stream
module tb_softmax_argmax_stream;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_lane_en;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [7:0]  out_data;
    logic        out_err;
    logic [8:0]  out_margin;

    int errors = 0;
    int checks = 0;

    byte fsc[0:39];
    bit  fen[0:39];

    typedef struct {
        int  n;
        bit  ramp;
        byte base;
        int  h1;
        byte v1;
        int  h2;
        byte v2;
        int  e_idx;
        int  e_data;
        bit  e_err;
        int  e_margin;
    } vec_t;
    vec_t vecs[8];

    softmax_argmax_stream dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lane_en(in_lane_en), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_data(out_data), .out_err(out_err), .out_margin(out_margin)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_beat(int b, bit last);
        int t = 0;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            in_data[k*8 +: 8] = fsc[b*4+k];
            in_lane_en[k]     = fen[b*4+k];
        end
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: in_ready stuck at %0b expected 1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(int nb);
        for (int b = 0; b < nb; b++) drive_beat(b, b == nb - 1);
    endtask

    task automatic check_result(string tag, int idx, int data, bit err, int margin);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_index"}, 32'(out_index), idx);
        chk({tag, "_data"},  32'(out_data), data);
        chk({tag, "_err"},   32'(out_err), 32'(err));
`ifdef SOFTMAX_TOP2_EN
        chk({tag, "_margin"}, 32'(out_margin), margin);
`else
        chk({tag, "_margin"}, 32'(out_margin), margin * 0);
`endif
    endtask

    function automatic int load_vec(vec_t v);
        for (int i = 0; i < 40; i++) begin
            fen[i] = 1'b0;
            fsc[i] = 8'h00;
        end
        for (int i = 0; i < v.n; i++) begin
            fen[i] = 1'b1;
            fsc[i] = v.ramp ? byte'(8'h80 + i) : v.base;
        end
        if (v.h1 >= 0) fsc[v.h1] = v.v1;
        if (v.h2 >= 0) fsc[v.h2] = v.v2;
        return (v.n == 0) ? 1 : (v.n + 3) / 4;
    endfunction

    // Reference: walk classes in order, keep best/second with plain integer compares.
    task automatic model(input int nb, output int idx, output int data, output bit err, output int margin);
        int best = 0, sec = 0, cnt = 0;
        bit has = 0, hs = 0, ovf = 0;
        idx = 0;
        for (int i = 0; i < nb * 4; i++) begin
            if (!fen[i]) continue;
            cnt++;
            if (i >= 32) ovf = 1;
            else if (!has || int'(fsc[i]) > best) begin
                if (has) begin sec = best; hs = 1; end
                best = int'(fsc[i]); idx = i; has = 1;
            end else if (!hs || int'(fsc[i]) > sec) begin
                sec = int'(fsc[i]); hs = 1;
            end
        end
        data   = has ? (best & 8'hFF) : 8'h80;
        err    = ovf || (cnt != 29);
        margin = !has ? 0 : (!hs ? 9'h1FF : best - sec);
    endtask

    initial begin
        int nb, e_idx, e_data, e_margin;
        bit e_err;

        vecs[0] = '{29, 1'b0, 8'hF0, 17, 8'h35, -1, 8'h00, 17, 8'h35, 1'b0, 9'h045};
        vecs[1] = '{29, 1'b0, 8'h00,  3, 8'h40, 22, 8'h40,  3, 8'h40, 1'b0, 9'h000};
        vecs[2] = '{29, 1'b0, 8'h00,  1, 8'h7F,  2, 8'h7F,  1, 8'h7F, 1'b0, 9'h000};
        vecs[3] = '{29, 1'b1, 8'h00, -1, 8'h00, -1, 8'h00, 28, 8'h9C, 1'b0, 9'h001};
        vecs[4] = '{29, 1'b0, 8'hF0,  0, 8'h10, -1, 8'h00,  0, 8'h10, 1'b0, 9'h020};
        vecs[5] = '{28, 1'b0, 8'h00,  5, 8'h22, -1, 8'h00,  5, 8'h22, 1'b1, 9'h022};
        vecs[6] = '{ 0, 1'b0, 8'h00, -1, 8'h00, -1, 8'h00,  0, 8'h80, 1'b1, 9'h000};
        vecs[7] = '{29, 1'b0, 8'hF0,  9, 8'h50, -1, 8'h00,  9, 8'h50, 1'b0, 9'h060};

        resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_lane_en = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(out_valid), 0);
        chk("rst_out_index",  32'(out_index), 0);
        chk("rst_out_data",   32'(out_data), 0);
        chk("rst_out_err",    32'(out_err), 0);
        chk("rst_out_margin", 32'(out_margin), 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        for (int v = 0; v < 8; v++) begin
            nb = load_vec(vecs[v]);
            run_frame(nb);
            check_result($sformatf("vec%0d", v), vecs[v].e_idx, vecs[v].e_data,
                         vecs[v].e_err, vecs[v].e_margin);
        end

        // Backpressure: hold result, offer a single-beat last frame, release coincident.
        nb = load_vec(vecs[0]);
        run_frame(nb);
        check_result("bp_first", 17, 8'h35, 1'b0, 9'h045);
        out_ready  = 1'b0;
        in_data    = 32'h03_09_02_01;
        in_lane_en = 4'hF;
        in_last    = 1'b1;
        in_valid   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready), 0);
            chk("bp_hold_data", 32'(out_data), 8'h35);
            chk("bp_hold_idx",  32'(out_index), 17);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_replace", 2, 8'h09, 1'b1, 9'h006);

        // Reset mid-frame discards the partial frame.
        nb = load_vec(vecs[1]);
        for (int b = 0; b < 4; b++) drive_beat(b, 1'b0);
        @(negedge clk) resetn = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 0);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        nb = load_vec(vecs[0]);
        run_frame(nb);
        check_result("midrst_next", 17, 8'h35, 1'b0, 9'h045);

        for (int r = 0; r < 40; r++) begin
            if (r % 3 == 0) begin
                nb = 8;
                for (int i = 0; i < 40; i++) begin
                    fen[i] = (i < 29);
                    fsc[i] = byte'($urandom);
                end
            end else begin
                nb = $urandom_range(1, 10);
                for (int i = 0; i < 40; i++) begin
                    fen[i] = (i < nb * 4) && ($urandom_range(0, 7) != 0);
                    fsc[i] = (r % 3 == 1) ? byte'($urandom_range(0, 3)) : byte'($urandom);
                end
            end
            model(nb, e_idx, e_data, e_err, e_margin);
            run_frame(nb);
            check_result($sformatf("rnd%0d", r), e_idx, e_data, e_err, e_margin);
            if ($urandom_range(0, 1) == 1) begin
                out_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rnd_hold_valid", 32'(out_valid), 1);
                    chk("rnd_hold_data",  32'(out_data), e_data);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
